// File: rtl/data_mem_port.sv
// data_mem_port: sequences N-bit word or byte loads/stores over a byte-wide memory, one byte per cycle.
//   clk, rst      : clock, synchronous active-high reset
//   req, we, size : request, 1 = store / 0 = load, 1 = byte / 0 = word access
//   addr, wdata   : byte address and store data, latched on accept
//   rdata         : load result (little-endian assembly, zero-extended for byte loads)
//   busy, done    : access in progress, one-cycle completion pulse
//   mem_*         : byte-wide memory port with combinational read data
module data_mem_port #(
    parameter int N      = 24,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic              size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [N-1:0]      wdata,
    output logic [N-1:0]      rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata
);
    localparam int NB = N / 8;
    localparam int KW = NB > 1 ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic                we_q, we_d, size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [N-1:0]        wdata_q, wdata_d, rdata_q, rdata_d;
    logic                last;

    // a byte access is always a single beat
    assign last = size_q || k_q == KW'(NB - 1);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req) begin
                we_d    = we;
                size_d  = size;
                addr_d  = addr;
                wdata_d = wdata;
                k_d     = '0;
                state_d = XFER;
            end
            XFER: begin
                if (!we_q) begin
                    if (size_q) begin
                        rdata_d      = '0;
                        rdata_d[7:0] = mem_rdata;
                    end else begin
                        for (int i = 0; i < NB; i++)
                            if (k_q == KW'(i)) rdata_d[8*i +: 8] = mem_rdata;
                    end
                end
                state_d = last ? DONE : XFER;
                k_d     = last ? '0 : k_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            we_q    <= 1'b0;
            size_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // address wraps silently modulo 2^ADDR_W
    assign mem_addr = state_q == XFER ? addr_q + ADDR_W'(k_q) : addr_q;
    assign mem_we   = state_q == XFER && we_q;
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign rdata    = rdata_q;

    always_comb begin
        mem_wdata = '0;
        if (mem_we)
            for (int i = 0; i < NB; i++)
                if (k_q == KW'(i)) mem_wdata = wdata_q[8*i +: 8];
    end
endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port: directed checks of data_mem_port against a byte-wide memory model.
module tb_data_mem_port;
    logic        clk = 1'b0;
    logic        rst, req, we, size;
    logic [13:0] addr;
    logic [23:0] wdata, rdata;
    logic        busy, done;
    logic [13:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we;

    logic [7:0]  mem [0:16383];
    int          tests = 0, fails = 0;
    int          lat, busy_cnt, we_cnt, nb, done_cnt;
    logic [13:0] addrs [4];

    data_mem_port #(.N(24), .ADDR_W(14)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task tick();
        @(posedge clk);
        #1;
    endtask

    // called just after the accept edge; returns with done visible
    task wait_done();
        lat = 1; busy_cnt = 0; we_cnt = 0; nb = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            if (mem_we) we_cnt++;
            if (nb < 4) begin
                addrs[nb] = mem_addr;
                nb++;
            end
            tick();
            lat++;
        end
        check("done_seen", done, 1'b1);
        if (busy) busy_cnt++;
    endtask

    task do_access(input logic w, input logic s, input logic [13:0] a, input logic [23:0] d);
        we = w; size = s; addr = a; wdata = d; req = 1'b1;
        tick();
        req = 1'b0;
        wait_done();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        rst = 1'b1; req = 1'b1; we = 1'b0; size = 1'b0; addr = 14'h0123; wdata = '0;
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 14'h0000);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_rdata", rdata, 24'h000000);
        rst = 1'b0; req = 1'b0;
        tick();

        // word load
        mem[14'h0100] = 8'h11; mem[14'h0101] = 8'h22; mem[14'h0102] = 8'h33;
        do_access(1'b0, 1'b0, 14'h0100, 24'h0);
        check("wl_rdata", rdata, 24'h332211);
        check("wl_latency", lat, 4);
        check("wl_busy_cycles", busy_cnt, 4);
        check("wl_we_cycles", we_cnt, 0);
        tick();
        check("wl_done_clear", done, 1'b0);
        check("wl_busy_clear", busy, 1'b0);
        check("idle_mem_addr", mem_addr, 14'h0100);
        check("idle_mem_wdata", mem_wdata, 8'h00);

        // word store
        do_access(1'b1, 1'b0, 14'h0200, 24'hABCDEF);
        check("ws_done_wdata", mem_wdata, 8'h00);
        check("ws_done_we", mem_we, 1'b0);
        tick();
        check("ws_b0", mem[14'h0200], 8'hEF);
        check("ws_b1", mem[14'h0201], 8'hCD);
        check("ws_b2", mem[14'h0202], 8'hAB);
        check("ws_we_cycles", we_cnt, 3);
        check("ws_latency", lat, 4);
        check("ws_rdata_kept", rdata, 24'h332211);

        // word load across address wrap
        mem[14'h3FFF] = 8'h44; mem[14'h0000] = 8'h55; mem[14'h0001] = 8'h66;
        do_access(1'b0, 1'b0, 14'h3FFF, 24'h0);
        check("wrap_a0", addrs[0], 14'h3FFF);
        check("wrap_a1", addrs[1], 14'h0000);
        check("wrap_a2", addrs[2], 14'h0001);
        check("wrap_rdata", rdata, 24'h665544);
        tick();

        // byte load zero-extends over prior all-ones rdata
        mem[14'h0400] = 8'hFF; mem[14'h0401] = 8'hFF; mem[14'h0402] = 8'hFF;
        do_access(1'b0, 1'b0, 14'h0400, 24'h0);
        check("ones_rdata", rdata, 24'hFFFFFF);
        tick();
        do_access(1'b0, 1'b1, 14'h0102, 24'h0);
        check("bl_rdata", rdata, 24'h000033);
        check("bl_latency", lat, 2);
        check("bl_busy_cycles", busy_cnt, 2);
        tick();

        // byte store writes only the low byte
        mem[14'h0501] = 8'h99;
        do_access(1'b1, 1'b1, 14'h0500, 24'h123456);
        tick();
        check("bs_b0", mem[14'h0500], 8'h56);
        check("bs_b1", mem[14'h0501], 8'h99);
        check("bs_we_cycles", we_cnt, 1);
        check("bs_rdata_kept", rdata, 24'h000033);

        // reset during a word store after its first beat
        mem[14'h0300] = 8'hAA; mem[14'h0301] = 8'hAA; mem[14'h0302] = 8'hAA;
        we = 1'b1; size = 1'b0; addr = 14'h0300; wdata = 24'h112233; req = 1'b1;
        tick();
        req = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_busy", busy, 1'b0);
        check("mr_mem_we", mem_we, 1'b0);
        check("mr_mem_addr", mem_addr, 14'h0000);
        check("mr_rdata", rdata, 24'h000000);
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (done || mem_we) done_cnt++;
            tick();
        end
        check("mr_no_done", done_cnt, 0);
        check("mr_b0", mem[14'h0300], 8'h33);
        check("mr_b1", mem[14'h0301], 8'hAA);
        check("mr_b2", mem[14'h0302], 8'hAA);

        // req held through DONE: one access, then a new accept at the first IDLE edge
        we = 1'b0; size = 1'b0; addr = 14'h0100; req = 1'b1;
        tick();
        wait_done();
        check("hold_rdata1", rdata, 24'h332211);
        tick();
        check("hold_idle", busy, 1'b0);
        addr = 14'h0200;
        tick();
        check("hold_reaccept", busy, 1'b1);
        req = 1'b0;
        wait_done();
        check("hold_rdata2", rdata, 24'hABCDEF);
        check("hold_latency", lat, 4);
        tick();
        check("hold_end_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
